spi_cfg_master: RTL and testbench
=================================

Name: spi_cfg_master

Overview:
- Controller/arbiter that shares one SPI write channel between two configuration requesters (A, B) and drives 16-bit write frames into the SPI register peripheral (PWM/output-enable registers).
- Round-robin arbitration.
- Valid/ready handshake per requester.
- Generates mode-0 SCLK/nCS/COPI, slow enough for the peripheral's 2-FF input synchronisers.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period; legal range 3..255.
CS_GAP, 8, minimum idle clk cycles with ncs high between frames, after the done cycle; legal range 1..255.
MAX_ADDR, 7'h04, highest legal register address; larger addresses are rejected, not sent.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
a_valid  in  1  requester A has a write pending
a_addr  in  7  requester A register address
a_data  in  8  requester A write data
a_ready  out  1  A request accepted this cycle
b_valid  in  1  requester B has a write pending
b_addr  in  7  requester B register address
b_data  in  8  requester B write data
b_ready  out  1  B request accepted this cycle
sclk  out  1  SPI clock, idle low
ncs  out  1  SPI chip select, active-low
copi  out  1  SPI data out, MSB first
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse when a frame completes (ncs rises)
err  out  1  one-cycle pulse when an accepted request had addr > MAX_ADDR

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: sclk=0, ncs=1, copi=0, busy=0, done=0, err=0, a_ready=b_ready=0. State=IDLE, RR pointer=A.
- Reset mid-frame: on the next clk edge, ncs=1 and sclk=0. The frame is abandoned, with no done and no err.
- Frame format: {1'b1 write bit, addr[6:0], data[7:0]}, transmitted bit 15 first.

Handshake:
- a_ready/b_ready are combinational and can only be high in IDLE.
- ready is asserted for the granted requester only; at most one ready is high per cycle.
- A transfer occurs on valid && ready.
- Requesters must hold valid, addr and data stable until ready.
- The controller latches addr/data on the transfer cycle.
- Arbitration: when only one requester is valid, it is granted.
- When both are valid, the requester indicated by the RR pointer is granted. After any grant, the pointer moves to the other requester. This includes rejected (err) grants.

State machine: IDLE -> SETUP -> SHIFT -> GAP -> IDLE.
- IDLE:
  - On a transfer with addr <= MAX_ADDR, go to SETUP.
  - On a transfer with addr > MAX_ADDR, pulse err in the next cycle and stay IDLE. ncs stays high.
- SETUP:
  - ncs=0, sclk=0, copi=bit15.
  - Lasts CLK_DIV cycles.
- SHIFT: 16 bits; each bit is a high phase followed by a low phase, each CLK_DIV cycles.
  - sclk rises at the start of each high phase.
  - copi updates to the next bit at each falling edge, i.e. the start of a low phase.
  - The 16th low phase is the nCS hold time.
- GAP:
  - Entered with ncs=1 and done=1 for exactly one cycle (the first GAP cycle).
  - Lasts CS_GAP cycles, then IDLE.

Timing:
- Transfer at cycle N -> ncs low from N+1 for exactly 33*CLK_DIV cycles.
- Exactly 16 sclk rising edges per frame, all while ncs=0.
- sclk is low whenever ncs changes.
- Minimum ncs-high time between frames is CS_GAP+1 cycles.
- Counters: the half-period counter is 8 bits; the bit counter is 5 bits and saturates at 16. No wrap is possible within a frame.
- A valid that arrives while busy is held off (ready=0). It is not dropped.

Test Plan:
1. Reset, then A writes addr=0x04, data=0xA5 with CLK_DIV=4 -> a_ready for 1 cycle; ncs low for 132 cycles; COPI sampled on sclk rise = 0x84A5; 16 rising edges; done pulse; no err.
2. A and B both valid from reset (A 0x00/0x11, B 0x01/0x22) -> order is A, B, then A again if A re-requests. Frames 0x8011 then 0x8122. Gap between them: ncs high for 9 cycles.
3. B addr=0x05 -> b_ready pulse, err pulse the next cycle, ncs never falls, pointer advances; a following A request is sent normally.
4. A valid while a frame is in progress -> a_ready stays 0 until IDLE; A's data is sent unchanged in the next frame.
5. Assert rst at the 5th sclk rising edge -> next cycle ncs=1, sclk=0, busy=0, no done. A new request afterwards produces a full correct frame.
6. Loopback to the SPI peripheral model with CLK_DIV=3 -> the peripheral register (addr 0x04) updates to the written data, 0x7F.

Source files
------------

// File: rtl/spi_cfg_master_if.sv
// Requester-side bus for spi_cfg_master: two independent write requesters (A and B).
// Handshake: a requester raises valid with addr/data and holds all three stable until
// ready; a transfer happens on the cycle valid && ready are both high (ready is combinational).
interface spi_cfg_master_if;
  logic       a_valid;
  logic [6:0] a_addr;
  logic [7:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [6:0] b_addr;
  logic [7:0] b_data;
  logic       b_ready;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/spi_cfg_master.sv
// Round-robin arbiter for two config requesters feeding one mode-0 SPI write channel.
// Frames are {1'b1, addr[6:0], data[7:0]}, MSB first, with slow SCLK for 2-FF synchronised slaves.
module spi_cfg_master #(
  parameter int         CLK_DIV  = 4,
  parameter int         CS_GAP   = 8,
  parameter logic [6:0] MAX_ADDR = 7'h04
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_cfg_master_if.slave       req,
  output logic                  sclk,
  output logic                  ncs,
  output logic                  copi,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_M1 = 8'(CS_GAP - 1);

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [4:0]  bit_cnt, bit_cnt_nx;
  logic        phase_lo, phase_lo_nx;
  logic [15:0] shreg, shreg_nx;
  logic        rr_b, rr_b_nx;
  logic        done_q, done_nx;
  logic        err_q, err_nx;
  logic        grant_a, grant_b;
  logic [6:0]  sel_addr;
  logic [7:0]  sel_data;

  // rr_b set means B wins a tie; ready never rises during reset
  assign grant_a  = (state == S_IDLE) && !rst && req.a_valid && (!req.b_valid || !rr_b);
  assign grant_b  = (state == S_IDLE) && !rst && req.b_valid && (!req.a_valid || rr_b);
  assign sel_addr = grant_a ? req.a_addr : req.b_addr;
  assign sel_data = grant_a ? req.a_data : req.b_data;

  assign req.a_ready = grant_a;
  assign req.b_ready = grant_b;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    bit_cnt_nx  = bit_cnt;
    phase_lo_nx = phase_lo;
    shreg_nx    = shreg;
    rr_b_nx     = rr_b;
    done_nx     = 1'b0;
    err_nx      = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_a || grant_b) begin
          rr_b_nx = grant_a;
          if (sel_addr > MAX_ADDR) begin
            err_nx = 1'b1;
          end else begin
            state_nx    = S_SETUP;
            shreg_nx    = {1'b1, sel_addr, sel_data};
            cnt_nx      = DIV_M1;
            bit_cnt_nx  = 5'd0;
            phase_lo_nx = 1'b0;
          end
        end
      end
      S_SETUP: begin
        if (cnt == 8'd0) begin
          state_nx    = S_SHIFT;
          cnt_nx      = DIV_M1;
          phase_lo_nx = 1'b0;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      S_SHIFT: begin
        if (cnt != 8'd0) begin
          cnt_nx = cnt - 8'd1;
        end else begin
          cnt_nx = DIV_M1;
          if (!phase_lo) begin
            // falling SCLK edge: present the next bit
            phase_lo_nx = 1'b1;
            shreg_nx    = {shreg[14:0], 1'b0};
          end else begin
            phase_lo_nx = 1'b0;
            if (bit_cnt != 5'd16) bit_cnt_nx = bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) begin
              state_nx = S_GAP;
              cnt_nx   = GAP_M1;
              done_nx  = 1'b1;
            end
          end
        end
      end
      S_GAP: begin
        if (cnt == 8'd0) state_nx = S_IDLE;
        else             cnt_nx   = cnt - 8'd1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 8'd0;
      bit_cnt  <= 5'd0;
      phase_lo <= 1'b0;
      shreg    <= 16'd0;
      rr_b     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bit_cnt  <= bit_cnt_nx;
      phase_lo <= phase_lo_nx;
      shreg    <= shreg_nx;
      rr_b     <= rr_b_nx;
      done_q   <= done_nx;
      err_q    <= err_nx;
    end
  end

  assign ncs       = !((state == S_SETUP) || (state == S_SHIFT));
  assign sclk      = (state == S_SHIFT) && !phase_lo;
  assign copi      = ncs ? 1'b0 : shreg[15];
  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: directed + random requests, SPI pin monitor against an
// expected-frame queue, plus a synchronised SPI register peripheral on a CLK_DIV=3 instance.
module tb_spi_cfg_master;
  localparam int         CLK_DIV  = 4;
  localparam int         CS_GAP   = 8;
  localparam logic [6:0] MAX_ADDR = 7'h04;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_cfg_master_if bus();
  spi_cfg_master_if bus3();
  logic sclk, ncs, copi, busy, done, err;
  logic [1:0] dbg_state;
  logic sclk3, ncs3, copi3, busy3, done3, err3;
  logic [1:0] dbg_state3;

  spi_cfg_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .MAX_ADDR(MAX_ADDR)) u_dut (
    .clk(clk), .rst(rst), .req(bus), .sclk(sclk), .ncs(ncs), .copi(copi),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  spi_cfg_master #(.CLK_DIV(3), .CS_GAP(CS_GAP), .MAX_ADDR(MAX_ADDR)) u_dut3 (
    .clk(clk), .rst(rst), .req(bus3), .sclk(sclk3), .ncs(ncs3), .copi(copi3),
    .busy(busy3), .done(done3), .err(err3), .dbg_state(dbg_state3)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [15:0] exp_q[$];
  int start_q[$];
  int err_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a write becomes a frame {1, addr, data} starting the cycle after
  // the transfer, or an err pulse that cycle when the address is out of range.
  task automatic model_accept(input logic [6:0] addr, input logic [7:0] data);
    if (addr <= MAX_ADDR) begin
      exp_q.push_back({1'b1, addr, data});
      start_q.push_back(cyc + 1);
    end else begin
      err_q.push_back(cyc + 1);
    end
  endtask

  // Arbitration model: lone requester wins; on a tie the pointer decides, then flips.
  int rr_model = 0;
  logic ga, gb;
  always @(negedge clk) begin
    if (rst) begin
      rr_model = 0;
      if (bus.a_valid || bus.b_valid) chk("ready_in_reset", {bus.a_ready, bus.b_ready}, 0);
    end else if (busy) begin
      if (bus.a_valid || bus.b_valid) chk("ready_while_busy", {bus.a_ready, bus.b_ready}, 0);
    end else if (bus.a_valid || bus.b_valid) begin
      ga = bus.a_valid && (!bus.b_valid || rr_model == 0);
      gb = bus.b_valid && !ga;
      chk("grant", {bus.a_ready, bus.b_ready}, {ga, gb});
      if (bus.a_valid && bus.a_ready) begin
        rr_model = 1;
        model_accept(bus.a_addr, bus.a_data);
      end else if (bus.b_valid && bus.b_ready) begin
        rr_model = 0;
        model_accept(bus.b_addr, bus.b_data);
      end
    end
  end

  // ---------------- SPI pin monitor ----------------
  logic [15:0] shift = '0;
  logic prev_sclk = 1'b0, prev_ncs = 1'b1;
  int low_cnt = 0, high_cnt = 0, edges = 0, last_gap = 0;
  bit skip_gap = 1'b1;
  bit abort_pending = 1'b0;

  always @(negedge clk) begin
    if (ncs !== prev_ncs) chk("sclk_low_at_ncs_edge", sclk, 0);
    if (!ncs && prev_ncs) begin
      if (start_q.size() == 0) chk("frame_unexpected", 0, 1);
      else chk("ncs_fall_cycle", cyc, start_q.pop_front());
      if (!skip_gap) chk("cs_gap_min", high_cnt >= CS_GAP + 1, 1);
      last_gap = high_cnt;
      skip_gap = 1'b0;
      low_cnt = 0;
      edges = 0;
      shift = '0;
    end
    if (ncs && !prev_ncs) begin
      if (abort_pending) begin
        chk("done_on_abort", done, 0);
        abort_pending = 1'b0;
        skip_gap = 1'b1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        chk("done_at_ncs_rise", done, 1);
        chk("sclk_edges", edges, 16);
        chk("ncs_low_cycles", low_cnt, 33 * CLK_DIV);
        if (exp_q.size() == 0) chk("frame_no_expect", 0, 1);
        else chk("frame_data", shift, exp_q.pop_front());
      end
      high_cnt = 0;
    end else if (done) begin
      chk("done_spurious", done, 0);
    end
    if (!ncs) begin
      low_cnt++;
      if (sclk && !prev_sclk) begin
        shift = {shift[14:0], copi};
        edges++;
      end
    end else begin
      high_cnt++;
      if (sclk) chk("sclk_while_ncs_high", sclk, 0);
    end
    if (err) begin
      if (err_q.size() == 0) chk("err_unexpected", 1, 0);
      else chk("err_cycle", cyc, err_q.pop_front());
      chk("ncs_high_on_err", ncs, 1);
    end
    prev_sclk = sclk;
    prev_ncs = ncs;
  end

  // ---------------- SPI register peripheral (2-FF synchronised inputs) ----------------
  logic [1:0] s_sclk = '0, s_ncs = '1, s_copi = '0;
  logic p_sclk = 1'b0, p_ncs = 1'b1;
  logic [15:0] p_shift = '0;
  int p_bits = 0;
  logic [7:0] preg [0:4];
  always @(posedge clk) begin
    s_sclk = {s_sclk[0], sclk3};
    s_ncs  = {s_ncs[0], ncs3};
    s_copi = {s_copi[0], copi3};
    if (rst) begin
      for (int i = 0; i < 5; i++) preg[i] = 8'h00;
      p_bits = 0;
    end else begin
      if (!s_ncs[1] && p_ncs) begin
        p_bits = 0;
        p_shift = '0;
      end
      if (!s_ncs[1] && s_sclk[1] && !p_sclk) begin
        p_shift = {p_shift[14:0], s_copi[1]};
        p_bits++;
      end
      if (s_ncs[1] && !p_ncs && p_bits == 16 && p_shift[15] && p_shift[14:8] <= 7'd4)
        preg[p_shift[10:8]] = p_shift[7:0];
    end
    p_sclk = s_sclk[1];
    p_ncs = s_ncs[1];
  end

  // ---------------- driver tasks ----------------
  task automatic wait_handshake(input bit is_b);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(is_b ? bus.b_ready : bus.a_ready) && t < 4000);
    if (!(is_b ? bus.b_ready : bus.a_ready)) chk(is_b ? "b_ready_timeout" : "a_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (is_b) begin
      bus.b_valid = 1'b0; bus.b_addr = 7'($urandom); bus.b_data = 8'($urandom);
    end else begin
      bus.a_valid = 1'b0; bus.a_addr = 7'($urandom); bus.a_data = 8'($urandom);
    end
  endtask

  task automatic req(input bit is_b, input logic [6:0] addr, input logic [7:0] data);
    @(posedge clk);
    #1;
    if (is_b) begin
      bus.b_valid = 1'b1; bus.b_addr = addr; bus.b_data = data;
    end else begin
      bus.a_valid = 1'b1; bus.a_addr = addr; bus.a_data = data;
    end
    wait_handshake(is_b);
  endtask

  task automatic midframe_reset(input int nth_edge);
    int n = 0, t = 0;
    logic prev = 1'b0;
    while (n < nth_edge && t < 4000) begin
      @(negedge clk);
      t++;
      if (sclk && !prev) n++;
      prev = sclk;
    end
    if (n < nth_edge) chk("reset_edge_timeout", 0, 1);
    @(posedge clk);
    #1;
    abort_pending = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ncs", ncs, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_busy", busy, 0);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0 || busy) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_exp_q_empty", exp_q.size(), 0);
    chk("drain_err_q_empty", err_q.size(), 0);
  endtask

  task automatic loop_write(input logic [6:0] addr, input logic [7:0] data);
    int t = 0;
    @(posedge clk);
    #1;
    bus3.a_valid = 1'b1; bus3.a_addr = addr; bus3.a_data = data;
    do begin
      @(negedge clk);
      t++;
    end while (!bus3.a_ready && t < 4000);
    @(posedge clk);
    #1;
    bus3.a_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done3 && t < 4000);
    chk("loop_done_seen", done3, 1);
    repeat (6) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus3.a_valid = 1'b0; bus3.a_addr = '0; bus3.a_data = '0;
    bus3.b_valid = 1'b0; bus3.b_addr = '0; bus3.b_data = '0;

    // both requesters already valid while reset is held
    bus.a_valid = 1'b1; bus.a_addr = 7'h00; bus.a_data = 8'h11;
    bus.b_valid = 1'b1; bus.b_addr = 7'h01; bus.b_data = 8'h22;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_sclk", sclk, 0);
    chk("reset_ncs", ncs, 1);
    chk("reset_copi", copi, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    fork
      wait_handshake(1'b0);
      wait_handshake(1'b1);
    join
    repeat (2) @(negedge clk);
    chk("gap_back_to_back", last_gap, CS_GAP + 1);

    // pointer back at A: A wins the tie with its 0x04/0xA5 write
    fork
      req(1'b0, 7'h04, 8'hA5);
      req(1'b1, 7'h02, 8'($urandom));
    join

    // out-of-range B write, then a normal A write
    req(1'b1, 7'h05, 8'h5C);
    req(1'b0, 7'h03, 8'h3E);

    // A arrives mid-frame and waits
    fork
      req(1'b1, 7'h01, 8'h5A);
      begin
        repeat (40) @(posedge clk);
        req(1'b0, 7'h00, 8'hC3);
      end
    join
    drain();

    // reset at the 5th SCLK rise, then a clean frame
    req(1'b0, 7'h04, 8'h96);
    midframe_reset(5);
    req(1'b1, 7'h03, 8'hE7);
    drain();

    for (int it = 0; it < 20; it++) begin
      int mode, da, db;
      mode = $urandom_range(0, 2);
      da = $urandom_range(0, 20);
      db = $urandom_range(0, 20);
      fork
        if (mode != 1) begin
          repeat (da) @(posedge clk);
          req(1'b0, 7'($urandom_range(0, 6)), 8'($urandom));
        end
        if (mode != 0) begin
          repeat (db) @(posedge clk);
          req(1'b1, 7'($urandom_range(0, 6)), 8'($urandom));
        end
      join
    end
    drain();

    // loopback into the peripheral with CLK_DIV=3
    loop_write(7'h04, 8'h7F);
    chk("periph_reg4", preg[4], 8'h7F);
    loop_write(7'h02, 8'h3C);
    chk("periph_reg2", preg[2], 8'h3C);
    chk("periph_reg4_kept", preg[4], 8'h7F);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
